// File: rtl/sequence_player_if.sv
// Bus between the pattern store / transport controls and the sequence player.
// The master drives mode, tempo and pattern; the slave (player) returns position and triggers.
interface sequence_player_if #(
  parameter int CNT_W = 24
);
  logic [1:0]       mode;
  logic [CNT_W-1:0] step_len;
  logic [3:0]       seq_smpl_1;
  logic [3:0]       seq_smpl_2;
  logic [3:0]       seq_smpl_3;
  logic [3:0]       seq_smpl_4;
  logic [3:0]       seq_smpl_5;
  logic [3:0]       seq_smpl_6;
  logic [3:0]       seq_smpl_7;
  logic [3:0]       seq_smpl_8;
  logic [2:0]       play_time_idx;
  logic [3:0]       smpl_trig;
  logic             bar_start;
  logic             playing;

  modport master (
    output mode, step_len,
    output seq_smpl_1, seq_smpl_2, seq_smpl_3, seq_smpl_4,
    output seq_smpl_5, seq_smpl_6, seq_smpl_7, seq_smpl_8,
    input  play_time_idx, smpl_trig, bar_start, playing
  );

  modport slave (
    input  mode, step_len,
    input  seq_smpl_1, seq_smpl_2, seq_smpl_3, seq_smpl_4,
    input  seq_smpl_5, seq_smpl_6, seq_smpl_7, seq_smpl_8,
    output play_time_idx, smpl_trig, bar_start, playing
  );
endinterface

// File: rtl/sequence_player.sv
// Plays back the 8-step x 4-sample pattern: walks the step index at a programmable tempo
// and emits a one-cycle trigger vector (plus a bar-start pulse) on every step entered.
module sequence_player #(
  parameter int CNT_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  sequence_player_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // A zero step length behaves as one cycle per step.
  function automatic logic [CNT_W-1:0] len_eff(input logic [CNT_W-1:0] len);
    return (len == '0) ? ONE : len;
  endfunction

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic [3:0]       r_trig;
  logic             r_bar;
  logic             r_playing;

  logic [3:0]       w_pattern [8];
  logic [2:0]       w_idx_nxt;
  logic             w_step_end;

  assign w_pattern[0] = bus.seq_smpl_1;
  assign w_pattern[1] = bus.seq_smpl_2;
  assign w_pattern[2] = bus.seq_smpl_3;
  assign w_pattern[3] = bus.seq_smpl_4;
  assign w_pattern[4] = bus.seq_smpl_5;
  assign w_pattern[5] = bus.seq_smpl_6;
  assign w_pattern[6] = bus.seq_smpl_7;
  assign w_pattern[7] = bus.seq_smpl_8;

  assign w_idx_nxt  = r_idx + 3'd1;
  // >= so a step_len shrunk below the running count ends the step on the next edge.
  assign w_step_end = (r_cnt >= (len_eff(bus.step_len) - ONE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_idx     <= 3'd0;
      r_trig    <= 4'd0;
      r_bar     <= 1'b0;
      r_playing <= 1'b0;
    end else if (bus.mode == 2'b00) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_idx     <= 3'd0;
      r_trig    <= 4'd0;
      r_bar     <= 1'b0;
      r_playing <= 1'b0;
    end else if (r_state == S_IDLE) begin
      // Entering play fires step 0 on the same edge; pause from idle does nothing.
      r_cnt <= '0;
      r_idx <= 3'd0;
      if (bus.mode == 2'b01) begin
        r_state   <= S_PLAY;
        r_trig    <= w_pattern[0];
        r_bar     <= 1'b1;
        r_playing <= 1'b1;
      end else begin
        r_trig    <= 4'd0;
        r_bar     <= 1'b0;
        r_playing <= 1'b0;
      end
    end else if (bus.mode[1]) begin
      r_state   <= S_PAUSE;
      r_trig    <= 4'd0;
      r_bar     <= 1'b0;
      r_playing <= 1'b0;
    end else begin
      // Playing, or resuming from pause: the resume edge counts but never retriggers.
      r_state   <= S_PLAY;
      r_playing <= 1'b1;
      if (w_step_end) begin
        r_cnt  <= '0;
        r_idx  <= w_idx_nxt;
        r_trig <= w_pattern[w_idx_nxt];
        r_bar  <= (w_idx_nxt == 3'd0);
      end else begin
        r_cnt  <= r_cnt + ONE;
        r_trig <= 4'd0;
        r_bar  <= 1'b0;
      end
    end
  end

  assign bus.play_time_idx = r_idx;
  assign bus.smpl_trig     = r_trig;
  assign bus.bar_start     = r_bar;
  assign bus.playing       = r_playing;

endmodule

// File: tb/tb_sequence_player.sv
// Scoreboard bench for sequence_player: each scenario queues the expected outputs per cycle
// and compares them against the DUT one step after the clock edge.
module tb_sequence_player;
  localparam int CNT_W = 24;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sequence_player_if #(.CNT_W(CNT_W)) bus();
  sequence_player #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  typedef struct packed {
    logic [2:0] idx;
    logic [3:0] trig;
    logic       bar;
    logic       play;
  } obs_t;

  obs_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic obs_t observe();
    obs_t o;
    o.idx  = bus.play_time_idx;
    o.trig = bus.smpl_trig;
    o.bar  = bus.bar_start;
    o.play = bus.playing;
    return o;
  endfunction

  function automatic obs_t mk(input int idx, input int trig, input bit bar, input bit play);
    obs_t o;
    o.idx  = 3'(idx);
    o.trig = 4'(trig);
    o.bar  = bar;
    o.play = play;
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("idx=%0d trig=%h bar=%b playing=%b", o.idx, o.trig, o.bar, o.play);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pattern_ramp();
    bus.seq_smpl_1 = 4'd1; bus.seq_smpl_2 = 4'd2; bus.seq_smpl_3 = 4'd3; bus.seq_smpl_4 = 4'd4;
    bus.seq_smpl_5 = 4'd5; bus.seq_smpl_6 = 4'd6; bus.seq_smpl_7 = 4'd7; bus.seq_smpl_8 = 4'd8;
  endtask

  task automatic pattern_fill(input logic [3:0] v);
    bus.seq_smpl_1 = v; bus.seq_smpl_2 = v; bus.seq_smpl_3 = v; bus.seq_smpl_4 = v;
    bus.seq_smpl_5 = v; bus.seq_smpl_6 = v; bus.seq_smpl_7 = v; bus.seq_smpl_8 = v;
  endtask

  task automatic go_idle();
    bus.mode = 2'b00;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.mode = 2'b01;
    bus.step_len = 24'd4;
    pattern_ramp();
    for (int c = 0; c < 3; c++) begin
      obs_t e, o;
      exp_q.push_back(mk(0, 0, 0, 0));
      tick();
      e = exp_q.pop_front();
      o = observe();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL reset_hold c%0d: got %s want %s", c, fmt(o), fmt(e));
      end
    end
    bus.mode = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    begin
      obs_t e, o;
      exp_q.push_back(mk(0, 0, 0, 0));
      tick();
      e = exp_q.pop_front();
      o = observe();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL reset_release: got %s want %s", fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_basic();
    go_idle();
    pattern_ramp();
    bus.step_len = 24'd4;
    bus.mode = 2'b01;
    for (int c = 0; c <= 32; c++) begin
      obs_t e, o;
      int   s;
      s = (c / 4) % 8;
      exp_q.push_back(mk(s, (c % 4 == 0) ? s + 1 : 0, (c % 4 == 0) && (s == 0), 1));
      tick();
      e = exp_q.pop_front();
      o = observe();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL basic c%0d: got %s want %s", c, fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_fast();
    go_idle();
    pattern_fill(4'hF);
    bus.step_len = 24'd1;
    bus.mode = 2'b01;
    for (int c = 0; c < 17; c++) begin
      obs_t e, o;
      exp_q.push_back(mk(c % 8, 4'hF, (c % 8) == 0, 1));
      tick();
      e = exp_q.pop_front();
      o = observe();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL fast_len1 c%0d: got %s want %s", c, fmt(o), fmt(e));
      end
    end
    // Zero length behaves as one; empty steps still advance and still mark the bar.
    go_idle();
    pattern_fill(4'h0);
    bus.step_len = 24'd0;
    bus.mode = 2'b01;
    for (int c = 0; c < 10; c++) begin
      obs_t e, o;
      exp_q.push_back(mk(c % 8, 0, (c % 8) == 0, 1));
      tick();
      e = exp_q.pop_front();
      o = observe();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL empty_len0 c%0d: got %s want %s", c, fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_pause();
    go_idle();
    pattern_ramp();
    bus.step_len = 24'd10;
    bus.mode = 2'b01;
    for (int c = 0; c < 24; c++) begin
      obs_t e, o;
      exp_q.push_back(mk(c / 10, (c % 10 == 0) ? (c / 10) + 1 : 0, c == 0, 1));
      tick();
      e = exp_q.pop_front();
      o = observe();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL pause_pre c%0d: got %s want %s", c, fmt(o), fmt(e));
      end
    end
    bus.mode = 2'b10;
    for (int c = 0; c < 20; c++) begin
      obs_t e, o;
      exp_q.push_back(mk(2, 0, 0, 0));
      tick();
      e = exp_q.pop_front();
      o = observe();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL pause_hold c%0d: got %s want %s", c, fmt(o), fmt(e));
      end
    end
    bus.mode = 2'b01;
    for (int k = 0; k <= 6; k++) begin
      obs_t e, o;
      exp_q.push_back(mk((k == 6) ? 3 : 2, (k == 6) ? 4 : 0, 0, 1));
      tick();
      e = exp_q.pop_front();
      o = observe();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL pause_resume k%0d: got %s want %s", k, fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_shrink();
    go_idle();
    pattern_ramp();
    bus.step_len = 24'd5;
    bus.mode = 2'b01;
    for (int c = 0; c <= 12; c++) begin
      obs_t e, o;
      int   s;
      if (c == 4) bus.step_len = 24'd2;
      if (c < 4) begin
        exp_q.push_back(mk(0, (c == 0) ? 1 : 0, c == 0, 1));
      end else begin
        s = 1 + (c - 4) / 2;
        exp_q.push_back(mk(s % 8, ((c - 4) % 2 == 0) ? (s % 8) + 1 : 0, 0, 1));
      end
      tick();
      e = exp_q.pop_front();
      o = observe();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL shrink c%0d: got %s want %s", c, fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_async_reset();
    go_idle();
    pattern_ramp();
    bus.step_len = 24'd4;
    bus.mode = 2'b01;
    tick();
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    begin
      obs_t e, o;
      exp_q.push_back(mk(0, 0, 0, 0));
      e = exp_q.pop_front();
      o = observe();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL async_reset: got %s want %s", fmt(o), fmt(e));
      end
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      obs_t e, o;
      exp_q.push_back(mk(c / 4, (c % 4 == 0) ? (c / 4) + 1 : 0, c == 0, 1));
      tick();
      e = exp_q.pop_front();
      o = observe();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL reset_restart c%0d: got %s want %s", c, fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_reenter();
    go_idle();
    pattern_ramp();
    bus.step_len = 24'd3;
    bus.mode = 2'b01;
    for (int c = 0; c < 8; c++) tick();
    bus.mode = 2'b00;
    begin
      obs_t e, o;
      exp_q.push_back(mk(0, 0, 0, 0));
      tick();
      e = exp_q.pop_front();
      o = observe();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL reenter_idle: got %s want %s", fmt(o), fmt(e));
      end
    end
    bus.mode = 2'b01;
    begin
      obs_t e, o;
      exp_q.push_back(mk(0, 1, 1, 1));
      tick();
      e = exp_q.pop_front();
      o = observe();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL reenter_play: got %s want %s", fmt(o), fmt(e));
      end
    end
    go_idle();
    for (int c = 0; c < 6; c++) begin
      obs_t e, o;
      bus.mode = (c < 3) ? 2'b11 : 2'b10;
      exp_q.push_back(mk(0, 0, 0, 0));
      tick();
      e = exp_q.pop_front();
      o = observe();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL idle_pause c%0d: got %s want %s", c, fmt(o), fmt(e));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fast();
    test_pause();
    test_shrink();
    test_async_reset();
    test_reenter();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
